custom_vec_banked_rf: RTL and testbench

- Banked storage for the custom vector extension, parametrised in word count, read-port count and bank count.
- One write port and NrReadPorts read ports.
- Each request is arbitrated per bank and returns registered read data one cycle after acceptance.
- Includes a hardware clear sequencer that zeroes the whole array. It sits between the issue stage's custom-vector operand fetch and the custom functional unit.

---
 rtl/custom_vec_banked_rf.sv | 186 ++++++++++++++++++
 tb/tb_custom_vec_banked_rf.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_vec_banked_rf.sv
// Banked vector register storage: one byte-masked write port, NrReadPorts arbitrated read ports,
// and a row-at-a-time clear sequencer. Optional read-conflict counter: CVA6_CUSTOMVEC_CONFLICT_CNT_EN.
module custom_vec_banked_rf #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NumWords    = 512,
  parameter int unsigned NrReadPorts = 2,
  parameter int unsigned NrBanks     = 4,
  localparam int unsigned AW         = $clog2(NumWords)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  output logic                          busy_o,
  input  logic [NrReadPorts-1:0]        rd_valid_i,
  input  logic [NrReadPorts*AW-1:0]     rd_addr_i,
  output logic [NrReadPorts-1:0]        rd_ready_o,
  output logic [NrReadPorts-1:0]        rd_rvalid_o,
  output logic [NrReadPorts*XLEN-1:0]   rd_data_o,
  input  logic                          we_i,
  input  logic [AW-1:0]                 waddr_i,
  input  logic [XLEN-1:0]               wdata_i,
  input  logic [XLEN/8-1:0]             wbe_i,
`ifdef CVA6_CUSTOMVEC_CONFLICT_CNT_EN
  output logic [31:0]                   conflict_cnt_o,
`endif
  output logic                          wready_o
);

  localparam int unsigned BankBits = $clog2(NrBanks);
  localparam int unsigned BW       = (NrBanks > 1) ? BankBits : 1;
  localparam int unsigned Rows     = NumWords / NrBanks;
  localparam int unsigned RW       = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned NA       = NrReadPorts + 1;  // read ports plus the write port

  // Handshake: a read request transfers when rd_valid_i[p] && rd_ready_o[p]; a port that is not
  // ready must hold valid and address. Data follows as a one-cycle rd_rvalid_o pulse.
  // Writes transfer when we_i && wready_o.

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic idle;

  logic [AW-1:0] addr_all [NA];
  logic [BW-1:0] bank_all [NA];
  logic [RW-1:0] row_all  [NA];

  logic [NrReadPorts-1:0] grant;
  logic                   wr_en;
  logic                   found, same;

  logic [XLEN-1:0]             mem_q [NrBanks][Rows];
  logic [NrReadPorts-1:0]      rvalid_q;
  logic [NrReadPorts*XLEN-1:0] rdata_q;

  // Index NrReadPorts of the address tables is the write port.
  for (genvar a = 0; a < NA; a++) begin : g_addr
    if (a < NrReadPorts) begin : g_rd
      assign addr_all[a] = rd_addr_i[a*AW +: AW];
    end else begin : g_wr
      assign addr_all[a] = waddr_i;
    end
    if (NrBanks > 1) begin : g_banked
      assign bank_all[a] = addr_all[a][BW-1:0];
    end else begin : g_single
      assign bank_all[a] = '0;
    end
    if (Rows > 1) begin : g_rows
      assign row_all[a] = addr_all[a][AW-1 -: RW];
    end else begin : g_onerow
      assign row_all[a] = '0;
    end
  end

  assign idle     = (state_q == IDLE);
  assign busy_o   = (state_q == CLEAR);
  assign wready_o = idle;
  assign wr_en    = we_i && idle;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (clear_i) state_d = CLEAR;
      end
      CLEAR: begin
        if (row_q == RW'(Rows - 1)) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // A port wins if no lower port targets its bank, or if the lowest such port has its exact address.
  always_comb begin
    grant = '0;
    found = 1'b0;
    same  = 1'b0;
    for (int p = 0; p < NrReadPorts; p++) begin
      found = 1'b0;
      same  = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (!found && rd_valid_i[q] && (bank_all[q] == bank_all[p])) begin
          found = 1'b1;
          same  = (addr_all[q] == addr_all[p]);
        end
      end
      grant[p] = idle && rd_valid_i[p] &&
                 !(wr_en && (bank_all[NrReadPorts] == bank_all[p])) &&
                 (!found || same);
    end
  end

  assign rd_ready_o = grant;

  always_ff @(posedge clk_i) begin
    if (busy_o) begin
      for (int b = 0; b < NrBanks; b++) mem_q[b][row_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (wbe_i[i]) mem_q[bank_all[NrReadPorts]][row_all[NrReadPorts]][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= grant;
      for (int p = 0; p < NrReadPorts; p++) begin
        if (grant[p]) rdata_q[p*XLEN +: XLEN] <= mem_q[bank_all[p]][row_all[p]];
      end
    end
  end

  assign rd_rvalid_o = rvalid_q;
  assign rd_data_o   = rdata_q;

`ifdef CVA6_CUSTOMVEC_CONFLICT_CNT_EN
  logic [31:0] cnt_q;
  logic [7:0]  stalls;
  logic [32:0] cnt_sum;

  always_comb begin
    stalls = '0;
    for (int p = 0; p < NrReadPorts; p++) begin
      stalls = stalls + 8'(rd_valid_i[p] & ~grant[p]);
    end
    cnt_sum = {1'b0, cnt_q} + 33'(stalls);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (idle) begin
      if (clear_i)          cnt_q <= '0;
      else if (cnt_sum[32]) cnt_q <= 32'hFFFF_FFFF;
      else                  cnt_q <= cnt_sum[31:0];
    end
  end

  assign conflict_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_custom_vec_banked_rf.sv
// Bench for custom_vec_banked_rf: directed scenarios plus randomized traffic against an
// array-based reference model of the bank arbitration, write, and clear rules.
module tb_custom_vec_banked_rf;

  localparam int XLEN = 64;
  localparam int NW   = 512;
  localparam int NP   = 2;
  localparam int NB   = 4;
  localparam int AW   = 9;
  localparam int ROWS = NW / NB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              busy;
  logic [NP-1:0]     rd_valid = '0;
  logic [NP*AW-1:0]  rd_addr = '0;
  logic [NP-1:0]     rd_ready, rd_rvalid;
  logic [NP*XLEN-1:0] rd_data;
  logic              we = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [XLEN-1:0]   wdata = '0;
  logic [XLEN/8-1:0] wbe = '0;
  logic              wready;
`ifdef CVA6_CUSTOMVEC_CONFLICT_CNT_EN
  logic [31:0]       conflict_cnt;
`endif

  always #5 clk = ~clk;

  custom_vec_banked_rf #(
    .XLEN(XLEN), .NumWords(NW), .NrReadPorts(NP), .NrBanks(NB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
    .rd_rvalid_o(rd_rvalid), .rd_data_o(rd_data),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
`ifdef CVA6_CUSTOMVEC_CONFLICT_CNT_EN
    .conflict_cnt_o(conflict_cnt),
`endif
    .wready_o(wready)
  );

  // Reference model state
  logic [XLEN-1:0] ref_mem [NW];
  logic [XLEN-1:0] ref_data [NP];
  logic [XLEN-1:0] exp_q [$];
  int              clear_rem;
  longint unsigned ref_cnt;

  logic [NP-1:0] obs_ready;
  logic          obs_busy;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            busy_cycles;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    clear_rem = 0;
    ref_cnt   = 0;
    exp_q.delete();
    for (int p = 0; p < NP; p++) ref_data[p] = '0;
  endtask

  // One clock: check combinational outputs at negedge, update the model, check results after posedge.
  task automatic cycle();
    logic [NP-1:0]   g;
    logic [AW-1:0]   a [NP];
    logic [XLEN-1:0] e;
    bit              idle;
    int              win;
    int              stalled;
    @(negedge clk);
    idle = (clear_rem == 0);
    g = '0;
    for (int p = 0; p < NP; p++) a[p] = rd_addr[p*AW +: AW];
    if (idle) begin
      for (int b = 0; b < NB; b++) begin
        if (we && (int'(waddr) % NB == b)) continue;
        win = -1;
        for (int p = 0; p < NP; p++)
          if (win < 0 && rd_valid[p] && (int'(a[p]) % NB == b)) win = p;
        if (win >= 0)
          for (int p = 0; p < NP; p++)
            if (rd_valid[p] && a[p] == a[win]) g[p] = 1'b1;
      end
    end
    obs_ready = rd_ready;
    obs_busy  = busy;
    check("busy", busy, clear_rem != 0);
    check("wready", wready, idle);
    check("rd_ready", rd_ready, g);
`ifdef CVA6_CUSTOMVEC_CONFLICT_CNT_EN
    check("conflict_cnt", conflict_cnt, ref_cnt);
    if (idle) begin
      if (clear) ref_cnt = 0;
      else begin
        stalled = 0;
        for (int p = 0; p < NP; p++) if (rd_valid[p] && !g[p]) stalled++;
        ref_cnt = ref_cnt + stalled;
        if (ref_cnt > 64'hFFFF_FFFF) ref_cnt = 64'hFFFF_FFFF;
      end
    end
`endif
    for (int p = 0; p < NP; p++) if (g[p]) exp_q.push_back(ref_mem[a[p]]);
    if (idle && we)
      for (int i = 0; i < XLEN/8; i++)
        if (wbe[i]) ref_mem[waddr][i*8 +: 8] = wdata[i*8 +: 8];
    if (idle) begin
      if (clear) clear_rem = ROWS;
    end else begin
      clear_rem--;
      if (clear_rem == 0) for (int w = 0; w < NW; w++) ref_mem[w] = '0;
    end
    @(posedge clk);
    #1;
    check("rd_rvalid", rd_rvalid, g);
    for (int p = 0; p < NP; p++) begin
      if (g[p]) begin
        e = exp_q.pop_front();
        ref_data[p] = e;
        check("rd_data", rd_data[p*XLEN +: XLEN], e);
      end else begin
        check("rd_data_hold", rd_data[p*XLEN +: XLEN], ref_data[p]);
      end
    end
  endtask

  task automatic set_rd(input int p, input logic v, input logic [AW-1:0] adr);
    rd_valid[p] = v;
    rd_addr[p*AW +: AW] = adr;
  endtask

  initial begin
    reset_model();
    for (int w = 0; w < NW; w++) ref_mem[w] = 'x;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_wready", wready, 1'b1);
    check("reset_rvalid", rd_rvalid, '0);
    check("reset_rdata", rd_data, '0);
`ifdef CVA6_CUSTOMVEC_CONFLICT_CNT_EN
    check("reset_cnt", conflict_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Bring the array to a known (zero) state
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (ROWS) cycle();

    // Full write then read
    we = 1'b1; waddr = 9'd5; wdata = 64'h1122334455667788; wbe = 8'hFF;
    cycle();
    we = 1'b0;
    set_rd(0, 1'b1, 9'd5);
    cycle();
    check("t1_ready", obs_ready, 2'b01);
    check("t1_data", rd_data[63:0], 64'h1122334455667788);
    set_rd(0, 1'b0, 9'd0);

    // Partial byte write
    we = 1'b1; waddr = 9'd5; wdata = 64'h00000000000000AA; wbe = 8'h01;
    cycle();
    we = 1'b0;
    set_rd(0, 1'b1, 9'd5);
    cycle();
    check("t2_data", rd_data[63:0], 64'h11223344556677AA);

    // Bank conflict: 4 and 8 share bank 0
    set_rd(0, 1'b1, 9'd4);
    set_rd(1, 1'b1, 9'd8);
    cycle();
    check("t3_ready_a", obs_ready, 2'b01);
    set_rd(0, 1'b0, 9'd0);
    cycle();
    check("t3_ready_b", obs_ready, 2'b10);
`ifdef CVA6_CUSTOMVEC_CONFLICT_CNT_EN
    check("t3_cnt", conflict_cnt, 32'd1);
`endif
    set_rd(1, 1'b0, 9'd0);

    // Broadcast of identical addresses
    we = 1'b1; waddr = 9'd9; wdata = 64'hCAFE_F00D_1234_5678; wbe = 8'hFF;
    cycle();
    we = 1'b0;
    set_rd(0, 1'b1, 9'd9);
    set_rd(1, 1'b1, 9'd9);
    cycle();
    check("t4_ready", obs_ready, 2'b11);
    check("t4_p0", rd_data[63:0], 64'hCAFE_F00D_1234_5678);
    check("t4_p1", rd_data[127:64], 64'hCAFE_F00D_1234_5678);
    set_rd(1, 1'b0, 9'd0);

    // Write to bank 2 stalls a bank-2 read for one cycle
    we = 1'b1; waddr = 9'd2; wdata = 64'h0102030405060708; wbe = 8'hFF;
    set_rd(0, 1'b1, 9'd6);
    cycle();
    check("t5_ready_a", obs_ready, 2'b00);
    we = 1'b0;
    cycle();
    check("t5_ready_b", obs_ready, 2'b01);

    // Read of the word being written returns the new data next cycle
    we = 1'b1; waddr = 9'd6; wdata = 64'h6666_7777_8888_9999; wbe = 8'hFF;
    cycle();
    check("t6_ready_a", obs_ready, 2'b00);
    we = 1'b0;
    cycle();
    check("t6_data", rd_data[63:0], 64'h6666_7777_8888_9999);
    set_rd(0, 1'b0, 9'd0);

    // Randomized traffic on a narrow address window to force conflicts
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(rd_valid[p] && !obs_ready[p])) begin
          rd_valid[p] = 1'($urandom_range(0, 1));
          rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NW - 1))
                                                            : AW'($urandom_range(0, 15));
        end
      end
      we    = ($urandom_range(0, 2) == 0);
      waddr = AW'($urandom_range(0, 15));
      wdata = {$urandom, $urandom};
      wbe   = 8'($urandom);
      cycle();
    end
    we = 1'b0;
    while (rd_valid != '0) begin
      rd_valid = rd_valid & ~obs_ready;
      cycle();
    end

    // Clear sequence
    wbe = 8'hFF;
    we = 1'b1; waddr = 9'd0;   wdata = 64'hA5A5_0000_0000_0001; cycle();
    waddr = 9'd255; wdata = 64'hA5A5_0000_0000_00FF; cycle();
    waddr = 9'd511; wdata = 64'hA5A5_0000_0000_01FF; cycle();
    we = 1'b0;
    set_rd(0, 1'b1, 9'd255);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("t7_trigger_ready", obs_ready, 2'b01);
    check("t7_preclear_data", rd_data[63:0], 64'hA5A5_0000_0000_00FF);
    set_rd(0, 1'b1, 9'd0);
    we = 1'b1; waddr = 9'd3; wdata = 64'h3333; wbe = 8'hFF;
    busy_cycles = 0;
    for (int i = 0; i < 140; i++) begin
      if (i == 60) clear = 1'b1;
      cycle();
      clear = 1'b0;
      if (obs_busy) busy_cycles++;
    end
    check("t7_clear_len", busy_cycles, 128);
    we = 1'b0;
    set_rd(0, 1'b1, 9'd0);
    set_rd(1, 1'b1, 9'd255);
    cycle();
    check("t7_addr0", rd_data[63:0], 64'd0);
    check("t7_addr255", rd_data[127:64], 64'd0);
    set_rd(0, 1'b1, 9'd511);
    set_rd(1, 1'b0, 9'd0);
    cycle();
    check("t7_addr511", rd_data[63:0], 64'd0);
    check("t7_rvalid511", rd_rvalid, 2'b01);
    set_rd(0, 1'b0, 9'd0);

    // Reset in the middle of a clear
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (40) cycle();
    rst_n = 1'b0;
    #1;
    check("t8_busy_reset", busy, 1'b0);
    check("t8_wready_reset", wready, 1'b1);
    check("t8_rdata_reset", rd_data, '0);
    reset_model();
    for (int w = 0; w < NW; w++) ref_mem[w] = 'x;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (ROWS) cycle();
    set_rd(1, 1'b1, 9'd100);
    cycle();
    check("t8_after_clear", rd_data[127:64], 64'd0);
    set_rd(1, 1'b0, 9'd0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
